// File: rtl/darwin_link_pkg.sv
// Shared definitions for the Darwin3 west-port req/ack link (RX and TX sides).
package darwin_link_pkg;

  // Link word width and matching AXIS byte-enable width
  localparam int LINK_DATA_W = 16;
  localparam int LINK_KEEP_W = LINK_DATA_W / 8;

  // Four-phase handshake FSM encoding, shared with the TX block
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } link_state_e;

  // Width of a counter that spans 0..n-1; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/darwin_rx_fifo.sv
// First-word-fall-through FIFO for received link words.
// Pointers carry one extra wrap bit so full and empty come straight from the registers.
module darwin_rx_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        head_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              do_push;
  logic              do_pop;

  // Same index with different wrap bits means the write side has lapped the read side
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;

  // Guards make overflow and underflow impossible regardless of the caller
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Head entry is visible without a read request
  assign head_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Storage write; contents need no reset because empty masks them
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  // Pointer advance on push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/darwin_rx_west.sv
// West-port receiver: synchronises the chip's 4-phase request, captures bundled data
// into a FIFO and presents it as an AXI4-Stream master with fixed-length packets.
module darwin_rx_west
  import darwin_link_pkg::*;
#(
  parameter int DATA_W      = LINK_DATA_W,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int PKT_LEN     = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             RX_DATA_WEST,
  input  logic                          RX_REQ_WEST,
  output logic                          RX_ACK_WEST,
  output logic [DATA_W-1:0]             M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic [DATA_W/8-1:0]           M_AXIS_TKEEP,
  output logic                          M_AXIS_TLAST,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   word_cnt
);

  localparam int BEAT_W = cnt_width(PKT_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  link_state_e            state_q;
  logic                   ack_q;
  logic [31:0]            word_cnt_q;
  logic [BEAT_W-1:0]      beat_q;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;

  // Request synchroniser; the data bus is deliberately not synchronised, it is stable by protocol
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RX_REQ_WEST};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Capture happens only on the IDLE->ACK transition; a full FIFO withholds the ack
  assign fifo_push = (state_q == IDLE) && req_s && !fifo_full;
  assign fifo_pop  = M_AXIS_TVALID && M_AXIS_TREADY;

  // Handshake FSM with registered ack and accepted-word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s && !fifo_full) begin
            state_q    <= ACK;
            ack_q      <= 1'b1;
            word_cnt_q <= word_cnt_q + 32'd1;
          end
        end
        ACK: begin
          if (!req_s) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  // Beat position within the current packet, advanced only by accepted beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
    end else if (fifo_pop) begin
      beat_q <= (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
    end
  end

  darwin_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (RX_DATA_WEST),
    .pop_i       (fifo_pop),
    .head_data_o (M_AXIS_TDATA),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  assign RX_ACK_WEST   = ack_q;
  assign M_AXIS_TVALID = !fifo_empty;
  assign M_AXIS_TKEEP  = '1;
  assign M_AXIS_TLAST  = M_AXIS_TVALID && (beat_q == BEAT_LAST);
  assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_darwin_rx_west.sv
// Directed bench for darwin_rx_west. A second instance with PKT_LEN=4 shares every input
// and is used for the packet-boundary scenario.
`timescale 1ns/1ps
module tb_darwin_rx_west;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_req = 1'b0;
  logic        tready = 1'b0;

  logic        rx_ack, tvalid, tlast;
  logic [15:0] tdata;
  logic [1:0]  tkeep;
  logic [4:0]  level;
  logic [31:0] wcnt;

  logic        rx_ack4, tvalid4, tlast4;
  logic [15:0] tdata4;
  logic [1:0]  tkeep4;
  logic [4:0]  level4;
  logic [31:0] wcnt4;

  always #5 clk = ~clk;

  darwin_rx_west u_dut (
    .clk(clk), .rst(rst), .RX_DATA_WEST(rx_data), .RX_REQ_WEST(rx_req), .RX_ACK_WEST(rx_ack),
    .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TKEEP(tkeep),
    .M_AXIS_TLAST(tlast), .fifo_level(level), .word_cnt(wcnt)
  );

  darwin_rx_west #(.PKT_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .RX_DATA_WEST(rx_data), .RX_REQ_WEST(rx_req), .RX_ACK_WEST(rx_ack4),
    .M_AXIS_TDATA(tdata4), .M_AXIS_TVALID(tvalid4), .M_AXIS_TREADY(tready), .M_AXIS_TKEEP(tkeep4),
    .M_AXIS_TLAST(tlast4), .fifo_level(level4), .word_cnt(wcnt4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Observed beats (sampled mid-cycle) and expected word order
  logic [15:0] rx_q[$];
  logic [15:0] rx4_q[$];
  logic        rx4_last_q[$];
  logic [15:0] exp_q[$];
  int          rx_base = 0, rx4_base = 0, exp_base = 0;

  logic        stall_chk = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic        t4_done = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid && tready) rx_q.push_back(tdata);
      if (tvalid4 && tready) begin
        rx4_q.push_back(tdata4);
        rx4_last_q.push_back(tlast4);
      end
      if (stall_chk && prev_stall) begin
        check("t4_stall_data", {16'h0, tdata4}, {16'h0, prev_data});
        check("t4_stall_last", {31'h0, tlast4}, {31'h0, prev_last});
      end
      prev_stall = tvalid4 && !tready;
      prev_data  = tdata4;
      prev_last  = tlast4;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark_bases();
    rx_base  = rx_q.size();
    rx4_base = rx4_q.size();
    exp_base = exp_q.size();
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    rx_req = 1'b0;
    tready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    mark_bases();
  endtask

  task automatic req_up(input logic [15:0] d);
    rx_data = d;
    rx_req  = 1'b1;
    exp_q.push_back(d);
  endtask

  // Returns the edge count at which ack reached v, or 0 if the budget expired
  task automatic wait_ack(input logic v, input int budget, output int edges);
    edges = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (rx_ack === v) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic send(input logic [15:0] d, input string tag);
    int e;
    req_up(d);
    wait_ack(1'b1, 200, e);
    if (e == 0) check({tag, "_ack_rise"}, {31'h0, rx_ack}, 32'd1);
    rx_req = 1'b0;
    wait_ack(1'b0, 200, e);
    if (e == 0) check({tag, "_ack_fall"}, {31'h0, rx_ack}, 32'd0);
  endtask

  task automatic drain_wait(input int n);
    for (int i = 0; i < 600; i++) begin
      if (rx_q.size() - rx_base >= n) break;
      tick();
    end
  endtask

  task automatic compare_stream(input string tag, input int n);
    logic [15:0] got;
    check({tag, "_count"}, 32'(rx_q.size() - rx_base), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = (rx_base + i < rx_q.size()) ? rx_q[rx_base + i] : 16'hxxxx;
      check({tag, "_data"}, {16'h0, got}, {16'h0, exp_q[exp_base + i]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int e;

    // Reset state, checked while reset is held
    tick();
    rst = 1'b1;
    #1;
    check("rst_ack",    {31'h0, rx_ack}, 32'd0);
    check("rst_tvalid", {31'h0, tvalid}, 32'd0);
    check("rst_tlast",  {31'h0, tlast},  32'd0);
    check("rst_level",  {27'h0, level},  32'd0);
    check("rst_wcnt",   wcnt,            32'd0);

    // 1: single word, latency in both handshake directions
    do_reset();
    tready = 1'b1;
    req_up(16'h1111);
    wait_ack(1'b1, 20, e);
    check("t1_ack_rise_edges", 32'(e), 32'd3);
    check("t1_tvalid", {31'h0, tvalid}, 32'd1);
    check("t1_tdata", {16'h0, tdata}, 32'h1111);
    check("t1_tkeep", {30'h0, tkeep}, 32'h3);
    rx_req = 1'b0;
    wait_ack(1'b0, 20, e);
    check("t1_ack_fall_edges", 32'(e), 32'd3);
    check("t1_wcnt", wcnt, 32'd1);

    // 2: burst of 40 words, free-flowing stream
    do_reset();
    tready = 1'b1;
    for (int i = 1; i <= 40; i++) send(16'(i * 16'h1111), "t2");
    drain_wait(40);
    compare_stream("t2", 40);
    check("t2_wcnt", wcnt, 32'd40);
    tick();
    tick();
    check("t2_level", {27'h0, level}, 32'd0);

    // 3: backpressure, 17th word held until the stream drains
    do_reset();
    for (int i = 0; i < 16; i++) send(16'h3000 + 16'(i), "t3");
    check("t3_level_full", {27'h0, level}, 32'd16);
    check("t3_wcnt16", wcnt, 32'd16);
    req_up(16'h3010);
    wait_ack(1'b1, 12, e);
    check("t3_ack_held", {31'h0, rx_ack}, 32'd0);
    check("t3_level_held", {27'h0, level}, 32'd16);
    tready = 1'b1;
    wait_ack(1'b1, 30, e);
    check("t3_ack_after_ready", {31'h0, rx_ack}, 32'd1);
    rx_req = 1'b0;
    wait_ack(1'b0, 30, e);
    drain_wait(17);
    compare_stream("t3", 17);
    check("t3_wcnt17", wcnt, 32'd17);

    // 4: PKT_LEN=4 instance, toggling ready, stable outputs during stalls
    do_reset();
    t4_done = 1'b0;
    stall_chk = 1'b1;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(16'h4000 + 16'(i), "t4");
        drain_wait(8);
        t4_done = 1'b1;
      end
      begin
        while (!t4_done) begin
          tick();
          tready = !tready;
        end
      end
    join
    stall_chk = 1'b0;
    tready = 1'b0;
    compare_stream("t4", 8);
    check("t4_beats4", 32'(rx4_q.size() - rx4_base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("t4_tlast", {31'h0, (rx4_base + i < rx4_last_q.size()) ? rx4_last_q[rx4_base + i] : 1'bx},
            {31'h0, (i == 3 || i == 7)});
    end
    check("t4_wcnt4", wcnt4, 32'd8);
    check("t4_level4", {27'h0, level4}, 32'd0);
    check("t4_ack4", {31'h0, rx_ack4}, 32'd0);
    check("t4_tkeep4", {30'h0, tkeep4}, 32'h3);

    // 5: asynchronous reset mid-handshake, then clean resumption
    do_reset();
    send(16'h5001, "t5");
    send(16'h5002, "t5");
    req_up(16'h5003);
    wait_ack(1'b1, 20, e);
    check("t5_level_pre", {27'h0, level}, 32'd3);
    check("t5_ack_pre", {31'h0, rx_ack}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_ack", {31'h0, rx_ack}, 32'd0);
    check("t5_rst_tvalid", {31'h0, tvalid}, 32'd0);
    check("t5_rst_level", {27'h0, level}, 32'd0);
    rx_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    mark_bases();
    tready = 1'b1;
    send(16'hABCD, "t5");
    drain_wait(1);
    compare_stream("t5", 1);
    check("t5_wcnt", wcnt, 32'd1);

    // 6: simultaneous push/pop at level 5, then pop while full
    do_reset();
    for (int i = 0; i < 5; i++) send(16'h6000 + 16'(i), "t6");
    check("t6_level5", {27'h0, level}, 32'd5);
    req_up(16'h6005);
    tick();
    tick();
    tready = 1'b1;
    check("t6_level_pre", {27'h0, level}, 32'd5);
    tick();
    tready = 1'b0;
    check("t6_level_pushpop", {27'h0, level}, 32'd5);
    check("t6_ack_pushpop", {31'h0, rx_ack}, 32'd1);
    check("t6_popped", 32'(rx_q.size() - rx_base), 32'd1);
    rx_req = 1'b0;
    wait_ack(1'b0, 20, e);
    for (int i = 6; i < 17; i++) send(16'h6000 + 16'(i), "t6");
    check("t6_level16", {27'h0, level}, 32'd16);
    req_up(16'h6011);
    repeat (5) tick();
    check("t6_ack_blocked", {31'h0, rx_ack}, 32'd0);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    check("t6_level_after_pop", {27'h0, level}, 32'd15);
    check("t6_no_push_same_cycle", {31'h0, rx_ack}, 32'd0);
    tick();
    check("t6_level_refill", {27'h0, level}, 32'd16);
    check("t6_push_next_cycle", {31'h0, rx_ack}, 32'd1);
    rx_req = 1'b0;
    wait_ack(1'b0, 20, e);
    tready = 1'b1;
    drain_wait(18);
    compare_stream("t6", 18);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
